// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel clock enable by integer division of clk,
// registered hsync/vsync/de, pixel coordinates and line/frame start strobes.
module vga_timing_gen #(
  parameter int unsigned DIV      = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 11,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 31,
  parameter int unsigned HS_POL   = 1,
  parameter int unsigned VS_POL   = 1,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          pixel_ce,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned DW       = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
  localparam logic          HS_ACT   = (HS_POL != 0);
  localparam logic          VS_ACT   = (VS_POL != 0);

  logic [DW-1:0] divcnt_q, divcnt_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic          ls_q, ls_d;
  logic          fs_q, fs_d;

  assign pixel_ce = en && (divcnt_q == '0);

  // Decode is taken from the advanced coordinates so syncs and x/y change on the same edge.
  always_comb begin
    divcnt_d = (divcnt_q == DIV_LAST) ? '0 : divcnt_q + 1'b1;
    x_d      = x_q + 1'b1;
    y_d      = y_q;
    if (x_q == X_LAST) begin
      x_d = '0;
      y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
    end
    hsync_d = ((32'(x_d) >= HS_START) && (32'(x_d) < HS_END)) ? HS_ACT : ~HS_ACT;
    vsync_d = ((32'(y_d) >= VS_START) && (32'(y_d) < VS_END)) ? VS_ACT : ~VS_ACT;
    de_d    = (32'(x_d) < H_ACTIVE) && (32'(y_d) < V_ACTIVE);
    ls_d    = (x_d == '0);
    fs_d    = (x_d == '0) && (y_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divcnt_q <= '0;
      x_q      <= X_LAST;
      y_q      <= Y_LAST;
      hsync_q  <= ~HS_ACT;
      vsync_q  <= ~VS_ACT;
      de_q     <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else if (!en) begin
      // Restart state: the next enabled pixel_ce lands on (0,0).
      divcnt_q <= '0;
      x_q      <= X_LAST;
      y_q      <= Y_LAST;
      hsync_q  <= ~HS_ACT;
      vsync_q  <= ~VS_ACT;
      de_q     <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      divcnt_q <= divcnt_d;
      if (pixel_ce) begin
        x_q     <= x_d;
        y_q     <= y_d;
        hsync_q <= hsync_d;
        vsync_q <= vsync_d;
        de_q    <= de_d;
        ls_q    <= ls_d;
        fs_q    <= fs_d;
      end
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing at DIV=4, plus a tiny 15x10 raster at DIV=1
// with active-low syncs so whole frames fit in a short run.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default-parameter instance
  logic       rst0, en0, ce0, hs0, vs0, de0, ls0, fs0;
  logic [9:0] x0, y0;
  vga_timing_gen dut0 (
    .clk(clk), .rst(rst0), .en(en0), .pixel_ce(ce0), .hsync(hs0), .vsync(vs0),
    .de(de0), .x(x0), .y(y0), .line_start(ls0), .frame_start(fs0)
  );

  // Small raster: H 8+2+3+2=15, V 6+1+2+1=10, active-low syncs, DIV=1
  logic       rst1, en1, ce1, hs1, vs1, de1, ls1, fs1;
  logic [3:0] x1, y1;
  vga_timing_gen #(
    .DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .XW(4), .YW(4)
  ) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .pixel_ce(ce1), .hsync(hs1), .vsync(vs1),
    .de(de1), .x(x1), .y(y1), .line_start(ls1), .frame_start(fs1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits for the next pixel_ce on dut0, then one more negedge so outputs show the new pixel.
  task automatic wait_tick0();
    bit seen = 1'b0;
    for (int k = 0; k < 16 && !seen; k++) begin
      @(negedge clk);
      if (ce0) seen = 1'b1;
    end
    chk("tick0_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int hs_cnt, vs_cnt, xe, ye, fs_prev, fs_last, fs_seen;
    rst0 = 1'b1; en0 = 1'b0;
    rst1 = 1'b1; en1 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state, defaults
    chk("rst_x", x0, 799);
    chk("rst_y", y0, 523);
    chk("rst_hsync", hs0, 0);
    chk("rst_vsync", vs0, 0);
    chk("rst_de", de0, 0);
    chk("rst_ls", ls0, 0);
    chk("rst_fs", fs0, 0);
    chk("rst_ce", ce0, 0);
    $display("reset state dut0 x=%0d y=%0d", x0, y0);

    // First pixel after enable
    rst0 = 1'b0; en0 = 1'b1;
    #1 chk("first_ce", ce0, 1);
    @(negedge clk);
    chk("first_x", x0, 0);
    chk("first_y", y0, 0);
    chk("first_de", de0, 1);
    chk("first_fs", fs0, 1);
    chk("first_ls", ls0, 1);
    chk("first_hsync", hs0, 0);
    chk("ce_after_first", ce0, 0);
    $display("first tick x=%0d y=%0d fs=%0d", x0, y0, fs0);

    // Divider cadence: one pulse every 4 clks
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("ce_cadence", ce0, (k % 4) == 2);
    end
    chk("x_after_cadence", x0, 3);
    $display("cadence done x=%0d", x0);

    // Remainder of line 0 and wrap into line 1
    hs_cnt = 0;
    for (int i = 4; i <= 800; i++) begin
      wait_tick0();
      xe = i % 800;
      ye = i / 800;
      chk("line_x", x0, xe);
      chk("line_y", y0, ye);
      chk("line_hsync", hs0, (xe >= 656) && (xe < 752));
      chk("line_de", de0, xe < 640);
      chk("line_ls", ls0, xe == 0);
      chk("line_fs", fs0, 0);
      if (hs0 === 1'b1) hs_cnt++;
    end
    chk("hsync_width", hs_cnt, 96);
    $display("line done hsync ticks=%0d x=%0d y=%0d", hs_cnt, x0, y0);

    // Drop en at x=300, y=1
    repeat (300) wait_tick0();
    chk("pre_drop_x", x0, 300);
    chk("pre_drop_y", y0, 1);
    en0 = 1'b0;
    #1 chk("drop_ce", ce0, 0);
    @(negedge clk);
    chk("drop_x", x0, 799);
    chk("drop_y", y0, 523);
    chk("drop_de", de0, 0);
    chk("drop_ls", ls0, 0);
    chk("drop_fs", fs0, 0);
    chk("drop_hsync", hs0, 0);
    chk("drop_vsync", vs0, 0);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk("hold_ce", ce0, 0);
      chk("hold_x", x0, 799);
    end
    en0 = 1'b1;
    #1 chk("reen_ce", ce0, 1);
    @(negedge clk);
    chk("reen_x", x0, 0);
    chk("reen_y", y0, 0);
    chk("reen_fs", fs0, 1);
    chk("reen_de", de0, 1);
    $display("en restart x=%0d y=%0d fs=%0d", x0, y0, fs0);

    // Asynchronous reset mid-line
    repeat (20) wait_tick0();
    chk("pre_rst_x", x0, 20);
    #2 rst0 = 1'b1;
    #1;
    chk("arst_x", x0, 799);
    chk("arst_y", y0, 523);
    chk("arst_de", de0, 0);
    chk("arst_ls", ls0, 0);
    chk("arst_fs", fs0, 0);
    chk("arst_hsync", hs0, 0);
    repeat (2) @(negedge clk);
    rst0 = 1'b0;
    @(negedge clk);
    chk("post_rst_x", x0, 0);
    chk("post_rst_y", y0, 0);
    chk("post_rst_fs", fs0, 1);
    $display("async reset resume x=%0d y=%0d", x0, y0);

    // Small raster, active-low syncs, DIV=1
    chk("rst1_hsync", hs1, 1);
    chk("rst1_vsync", vs1, 1);
    chk("rst1_x", x1, 14);
    chk("rst1_y", y1, 9);
    chk("rst1_de", de1, 0);
    chk("rst1_ce", ce1, 0);
    rst1 = 1'b0; en1 = 1'b1;
    vs_cnt = 0; fs_prev = -1; fs_last = -1; fs_seen = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      xe = n % 15;
      ye = (n / 15) % 10;
      chk("s_ce", ce1, 1);
      chk("s_x", x1, xe);
      chk("s_y", y1, ye);
      chk("s_hsync", hs1, !((xe >= 10) && (xe < 13)));
      chk("s_vsync", vs1, !((ye >= 7) && (ye < 9)));
      chk("s_de", de1, (xe < 8) && (ye < 6));
      chk("s_ls", ls1, xe == 0);
      chk("s_fs", fs1, (xe == 0) && (ye == 0));
      if (vs1 === 1'b0) vs_cnt++;
      if (fs1 === 1'b1) begin
        fs_prev = fs_last;
        fs_last = n;
        fs_seen++;
      end
    end
    chk("s_fs_count", fs_seen, 2);
    chk("s_fs_period", fs_last - fs_prev, 150);
    chk("s_vsync_low", vs_cnt, 60);
    $display("small raster frames=%0d vsync low ticks=%0d", fs_seen, vs_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
